mem_copy_dma: RTL

Block-copy bus initiator for the pipelined CPU's data bus. Given a source address, destination address and word count, it drives the same Address / Write_data / MemRead / MemWrite / Read_data interface that the CPU memory stage uses, alternating one read cycle and one write cycle per word. It sits beside the CPU memory stage behind a bus-grant arbiter and talks to the data memory and timer/LED/digit peripheral map as an ordinary initiator.

---
 rtl/mem_copy_dma.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem_copy_dma.sv
// Block-copy bus initiator: one read cycle then one write cycle per word, ascending addresses.
// Optional feature: define DMA_IRQ_EN to drive irq high during the completion (DONE) cycle.
module mem_copy_dma #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 abort,
  input  logic                 bus_grant,
  input  logic [31:0]          Read_data,
  output logic [31:0]          Address,
  output logic [31:0]          Write_data,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [LEN_WIDTH-1:0] words_done,
  output logic                 irq
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q;
  logic [31:0]          src_ptr_q;
  logic [31:0]          dst_ptr_q;
  logic [31:0]          data_q;
  logic [LEN_WIDTH-1:0] remaining_q;
  logic [LEN_WIDTH-1:0] words_done_q;
  logic                 error_q;

  logic [LEN_WIDTH-1:0] remaining_d;
  logic [LEN_WIDTH-1:0] words_done_d;
  logic [31:0]          src_ptr_d;
  logic [31:0]          dst_ptr_d;
  logic                 misaligned;

  // Pointers wrap naturally modulo 2^32.
  assign remaining_d  = remaining_q - LEN_WIDTH'(1);
  assign words_done_d = words_done_q + LEN_WIDTH'(1);
  assign src_ptr_d    = src_ptr_q + 32'd4;
  assign dst_ptr_d    = dst_ptr_q + 32'd4;
  assign misaligned   = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      src_ptr_q    <= '0;
      dst_ptr_q    <= '0;
      data_q       <= '0;
      remaining_q  <= '0;
      words_done_q <= '0;
      error_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            src_ptr_q    <= src_addr;
            dst_ptr_q    <= dst_addr;
            remaining_q  <= len;
            words_done_q <= '0;
            if (misaligned) begin
              error_q <= 1'b1;
              state_q <= DONE;
            end else begin
              error_q <= 1'b0;
              state_q <= (len == '0) ? DONE : READ;
            end
          end
        end
        READ: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (bus_grant) begin
            data_q  <= Read_data;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (bus_grant) begin
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            words_done_q <= words_done_d;
            remaining_q  <= remaining_d;
            state_q      <= (remaining_d == '0) ? DONE : READ;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Bus outputs come from registered state only; grant and abort merely gate the strobes.
  always_comb begin
    Address    = 32'd0;
    Write_data = 32'd0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    unique case (state_q)
      READ: begin
        Address = src_ptr_q;
        MemRead = bus_grant & ~abort;
      end
      WRITE: begin
        Address    = dst_ptr_q;
        Write_data = data_q;
        MemWrite   = bus_grant & ~abort;
      end
      default: begin
        Address = 32'd0;
      end
    endcase
  end

  assign busy       = (state_q == READ) || (state_q == WRITE);
  assign done       = (state_q == DONE);
  assign error      = error_q;
  assign words_done = words_done_q;

`ifdef DMA_IRQ_EN
  assign irq = (state_q == DONE);
`else
  assign irq = 1'b0;
`endif

endmodule
